word_lane_serdes: RTL and testbench

WORD_LANE_SERDES -- requirements
Module: word_lane_serdes

---
 rtl/word_lane_serdes.sv | 161 ++++++++++++++++
 tb/tb_word_lane_serdes.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/word_lane_serdes.sv
// word_lane_serdes
//   Bidirectional word <-> lane converter. In P2S mode a LANES*LANE_W word
//   is accepted on the p-side handshake and streamed out one lane per
//   s-side transfer. In S2P mode lanes are collected from the s-side and the
//   assembled word is presented on the p-side until taken.
//
// Ports
//   clk, rst      : clock, asynchronous active-low reset
//   mode          : 0 = P2S, 1 = S2P (sampled only while idle)
//   abort         : synchronous flush back to idle
//   pvalid_i/pready_o/pdata_i          : P2S word input
//   svalid_o/sready_i/sdata_o/slast_o  : P2S lane output
//   svalid_i/sready_o/sdata_i          : S2P lane input
//   pvalid_o/pready_i/pdata_o          : S2P word output
//   busy_o        : high whenever not idle
module word_lane_serdes #(
  parameter int LANE_W    = 8,
  parameter int LANES     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic                      abort,
  input  logic                      pvalid_i,
  output logic                      pready_o,
  input  logic [LANE_W*LANES-1:0]   pdata_i,
  output logic                      svalid_o,
  input  logic                      sready_i,
  output logic [LANE_W-1:0]         sdata_o,
  output logic                      slast_o,
  input  logic                      svalid_i,
  output logic                      sready_o,
  input  logic [LANE_W-1:0]         sdata_i,
  output logic                      pvalid_o,
  input  logic                      pready_i,
  output logic [LANE_W*LANES-1:0]   pdata_o,
  output logic                      busy_o
);

  localparam int WORD_W = LANE_W * LANES;
  localparam int CNT_W  = $clog2(LANES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LANES - 1);

  typedef enum logic [1:0] {IDLE, P2S_SHIFT, S2P_COLLECT, S2P_HOLD} state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [WORD_W-1:0]   shift_reg;   // word being serialised
  logic [WORD_W-1:0]   word_reg;    // word being collected
  logic [WORD_W-1:0]   word_next;
  logic [WORD_W-1:0]   pdata_reg;   // last completed S2P word
  logic                load;        // capture pdata_i into shift_reg
  logic                lane_wr;     // write sdata_i into lane cnt
  logic                capture;     // final lane accepted: publish word
  logic [LANE_W-1:0]   shift_lane [LANES];

  // Lane k sits at the top of the word when MSB_FIRST, at the bottom
  // otherwise. The same mapping serves both directions.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam int POS = (MSB_FIRST != 0) ? (LANES - 1 - gi) : gi;
    assign shift_lane[gi] = shift_reg[POS*LANE_W +: LANE_W];
    assign word_next[POS*LANE_W +: LANE_W] =
      (lane_wr && (cnt_reg == CNT_W'(gi))) ? sdata_i : word_reg[POS*LANE_W +: LANE_W];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      shift_reg <= '0;
      word_reg  <= '0;
      pdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      word_reg  <= word_next;
      if (load)    shift_reg <= pdata_i;
      if (capture) pdata_reg <= word_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    load       = 1'b0;
    lane_wr    = 1'b0;
    capture    = 1'b0;
    pready_o   = 1'b0;
    svalid_o   = 1'b0;
    slast_o    = 1'b0;
    sready_o   = 1'b0;
    pvalid_o   = 1'b0;
    busy_o     = (state_reg != IDLE);

    unique case (state_reg)
      IDLE: begin
        if (!mode) begin
          pready_o = 1'b1;
          if (pvalid_i) begin
            load       = 1'b1;
            cnt_next   = '0;
            state_next = P2S_SHIFT;
          end
        end else begin
          cnt_next   = '0;
          state_next = S2P_COLLECT;
        end
      end
      P2S_SHIFT: begin
        svalid_o = 1'b1;
        slast_o  = (cnt_reg == LAST_CNT);
        // Final lane leaving this cycle frees the shift register, so a new
        // word can be taken on the same edge with no bubble.
        pready_o = (cnt_reg == LAST_CNT) && sready_i;
        if (sready_i) begin
          if (cnt_reg == LAST_CNT) begin
            cnt_next = '0;
            if (pvalid_i) load = 1'b1;
            else          state_next = IDLE;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      S2P_COLLECT: begin
        sready_o = 1'b1;
        if (svalid_i) begin
          lane_wr = 1'b1;
          if (cnt_reg == LAST_CNT) begin
            capture    = 1'b1;
            cnt_next   = '0;
            state_next = S2P_HOLD;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      S2P_HOLD: begin
        pvalid_o = 1'b1;
        if (pready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Abort wins over any handshake; readies drop so no transfer is implied.
    if (abort) begin
      state_next = IDLE;
      cnt_next   = '0;
      load       = 1'b0;
      lane_wr    = 1'b0;
      capture    = 1'b0;
      pready_o   = 1'b0;
      sready_o   = 1'b0;
    end
  end

  assign sdata_o = (state_reg == P2S_SHIFT) ? shift_lane[cnt_reg] : '0;
  assign pdata_o = pdata_reg;

endmodule

// File: tb/tb_word_lane_serdes.sv
module tb_word_lane_serdes;
  logic clk = 1'b0, rst = 1'b0, mode = 1'b0, abort = 1'b0;
  logic pvalid_i = 1'b0, sready_i = 1'b0, svalid_i = 1'b0, pready_i = 1'b0;
  logic [31:0] pdata_i = '0;
  logic [7:0]  sdata_i = '0;

  logic pready_o, svalid_o, slast_o, sready_o, pvalid_o, busy_o;
  logic [7:0]  sdata_o;
  logic [31:0] pdata_o;
  logic pready_l, svalid_l, slast_l, sready_l, pvalid_l, busy_l;
  logic [7:0]  sdata_l;
  logic [31:0] pdata_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  word_lane_serdes dut (
    .clk(clk), .rst(rst), .mode(mode), .abort(abort),
    .pvalid_i(pvalid_i), .pready_o(pready_o), .pdata_i(pdata_i),
    .svalid_o(svalid_o), .sready_i(sready_i), .sdata_o(sdata_o), .slast_o(slast_o),
    .svalid_i(svalid_i), .sready_o(sready_o), .sdata_i(sdata_i),
    .pvalid_o(pvalid_o), .pready_i(pready_i), .pdata_o(pdata_o), .busy_o(busy_o)
  );

  word_lane_serdes #(.MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst), .mode(mode), .abort(abort),
    .pvalid_i(pvalid_i), .pready_o(pready_l), .pdata_i(pdata_i),
    .svalid_o(svalid_l), .sready_i(sready_i), .sdata_o(sdata_l), .slast_o(slast_l),
    .svalid_i(svalid_i), .sready_o(sready_l), .sdata_i(sdata_i),
    .pvalid_o(pvalid_l), .pready_i(pready_i), .pdata_o(pdata_l), .busy_o(busy_l)
  );

  task automatic test_reset();
    rst = 1'b0;
    #3;
    checks++;
    if ({svalid_o, slast_o, sready_o, pvalid_o, busy_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000", {svalid_o, slast_o, sready_o, pvalid_o, busy_o});
    end
    checks++;
    if (sdata_o !== 8'h00 || pdata_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got sdata=%h pdata=%h want 0", sdata_o, pdata_o);
    end
    @(negedge clk) rst = 1'b1;
    #1;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_busy: got %b want 0", busy_o);
    end
    $display("reset done");
  endtask

  task automatic test_p2s_basic();
    logic [7:0] exp_lane [4];
    exp_lane = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    @(negedge clk);
    mode = 1'b0; pdata_i = 32'hA1B2C3D4; pvalid_i = 1'b1; sready_i = 1'b1;
    #1;
    checks++;
    if (pready_o !== 1'b1) begin
      errors++;
      $display("FAIL p2s_idle_pready: got %b want 1", pready_o);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pvalid_i = 1'b0;
      #1;
      $display("p2s lane %0d sdata=%h slast=%b", i, sdata_o, slast_o);
      checks++;
      if (svalid_o !== 1'b1 || sdata_o !== exp_lane[i] || slast_o !== (i == 3)) begin
        errors++;
        $display("FAIL p2s_lane%0d: got v=%b d=%h last=%b want v=1 d=%h last=%b",
                 i, svalid_o, sdata_o, slast_o, exp_lane[i], (i == 3));
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy_o !== 1'b0 || svalid_o !== 1'b0) begin
      errors++;
      $display("FAIL p2s_end_idle: got busy=%b svalid=%b want 0 0", busy_o, svalid_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_lane [8];
    exp_lane = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    @(negedge clk);
    pdata_i = 32'h01020304; pvalid_i = 1'b1; sready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      pdata_i  = 32'h05060708;
      pvalid_i = (i < 4);
      #1;
      $display("b2b lane %0d sdata=%h", i, sdata_o);
      checks++;
      if (svalid_o !== 1'b1 || sdata_o !== exp_lane[i] || slast_o !== (i == 3 || i == 7)) begin
        errors++;
        $display("FAIL b2b_lane%0d: got v=%b d=%h last=%b want v=1 d=%h last=%b",
                 i, svalid_o, sdata_o, slast_o, exp_lane[i], (i == 3 || i == 7));
      end
      if (i == 3) begin
        checks++;
        if (pready_o !== 1'b1) begin
          errors++;
          $display("FAIL b2b_reload_pready: got %b want 1", pready_o);
        end
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end_idle: got busy=%b want 0", busy_o);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_lane [4];
    logic [3:0] pat;
    int k, c;
    exp_lane = '{8'hCA, 8'hFE, 8'hBA, 8'hBE};
    pat = 4'b1001;
    k = 0;
    c = 0;
    @(negedge clk);
    pdata_i = 32'hCAFEBABE; pvalid_i = 1'b1; sready_i = 1'b1;
    while (k < 4 && c < 24) begin
      @(negedge clk);
      pvalid_i = 1'b0;
      sready_i = pat[c % 4];
      #1;
      $display("bp cycle %0d sready=%b sdata=%h", c, sready_i, sdata_o);
      checks++;
      if (svalid_o !== 1'b1 || sdata_o !== exp_lane[k] || slast_o !== (k == 3)) begin
        errors++;
        $display("FAIL bp_cycle%0d: got v=%b d=%h last=%b want v=1 d=%h last=%b",
                 c, svalid_o, sdata_o, slast_o, exp_lane[k], (k == 3));
      end
      if (sready_i) k++;
      c++;
    end
    checks++;
    if (k != 4) begin
      errors++;
      $display("FAIL bp_timeout: got %0d lanes want 4", k);
    end
    @(negedge clk);
    sready_i = 1'b1;
    #1;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_end_idle: got busy=%b want 0", busy_o);
    end
  endtask

  task automatic test_s2p();
    logic       v [5];
    logic [7:0] d [5];
    v = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    d = '{8'h11, 8'h22, 8'hFF, 8'h33, 8'h44};
    @(negedge clk);
    mode = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      svalid_i = v[j]; sdata_i = d[j];
      #1;
      checks++;
      if (sready_o !== 1'b1 || sready_l !== 1'b1) begin
        errors++;
        $display("FAIL s2p_sready%0d: got %b/%b want 1/1", j, sready_o, sready_l);
      end
    end
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      svalid_i = 1'b0; pready_i = 1'b0;
      #1;
      $display("s2p hold %0d pdata_lsb=%h pdata_msb=%h", h, pdata_l, pdata_o);
      checks++;
      if (pvalid_l !== 1'b1 || pdata_l !== 32'h44332211 || pdata_o !== 32'h11223344) begin
        errors++;
        $display("FAIL s2p_hold%0d: got v=%b lsb=%h msb=%h want v=1 lsb=44332211 msb=11223344",
                 h, pvalid_l, pdata_l, pdata_o);
      end
    end
    @(negedge clk);
    pready_i = 1'b1; mode = 1'b0;
    #1;
    checks++;
    if (pvalid_l !== 1'b1 || busy_l !== 1'b1) begin
      errors++;
      $display("FAIL s2p_take: got v=%b busy=%b want 1 1", pvalid_l, busy_l);
    end
    @(negedge clk);
    pready_i = 1'b0;
    #1;
    checks++;
    if (pvalid_l !== 1'b0 || busy_l !== 1'b0 || pdata_l !== 32'h44332211) begin
      errors++;
      $display("FAIL s2p_after: got v=%b busy=%b pdata=%h want 0 0 44332211", pvalid_l, busy_l, pdata_l);
    end
  endtask

  task automatic test_abort();
    logic [7:0] d [4];
    d = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    @(negedge clk);
    mode = 1'b1;
    @(negedge clk);
    svalid_i = 1'b1; sdata_i = 8'h12;
    @(negedge clk);
    sdata_i = 8'h34;
    @(negedge clk);
    abort = 1'b1; sdata_i = 8'h56;
    @(negedge clk);
    abort = 1'b0; svalid_i = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || sready_o !== 1'b0 || pvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got busy=%b sready=%b pvalid=%b want 0 0 0", busy_o, sready_o, pvalid_o);
    end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      svalid_i = 1'b1; sdata_i = d[j];
    end
    @(negedge clk);
    svalid_i = 1'b0; mode = 1'b0;
    #1;
    $display("abort result pdata=%h", pdata_o);
    checks++;
    if (pvalid_o !== 1'b1 || pdata_o !== 32'hAABBCCDD) begin
      errors++;
      $display("FAIL abort_word: got v=%b pdata=%h want 1 aabbccdd", pvalid_o, pdata_o);
    end
    @(negedge clk);
    pready_i = 1'b1;
    @(negedge clk);
    pready_i = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_end_idle: got busy=%b want 0", busy_o);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    pdata_i = 32'h55667788; pvalid_i = 1'b1; sready_i = 1'b1;
    @(negedge clk);
    pvalid_i = 1'b0;
    #1;
    checks++;
    if (sdata_o !== 8'h55) begin
      errors++;
      $display("FAIL arst_pre_lane: got %h want 55", sdata_o);
    end
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    $display("async reset mid-p2s sdata=%h pdata=%h", sdata_o, pdata_o);
    checks++;
    if ({svalid_o, slast_o, sready_o, pvalid_o, busy_o} !== 5'b0) begin
      errors++;
      $display("FAIL arst_flags: got %b want 00000", {svalid_o, slast_o, sready_o, pvalid_o, busy_o});
    end
    checks++;
    if (sdata_o !== 8'h00 || pdata_o !== 32'h0 || pdata_l !== 32'h0) begin
      errors++;
      $display("FAIL arst_data: got sdata=%h pdata=%h pdata_lsb=%h want 0", sdata_o, pdata_o, pdata_l);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (busy_o !== 1'b0 || svalid_o !== 1'b0) begin
      errors++;
      $display("FAIL arst_release: got busy=%b svalid=%b want 0 0", busy_o, svalid_o);
    end
  endtask

  initial begin
    test_reset();
    test_p2s_basic();
    test_back_to_back();
    test_backpressure();
    test_s2p();
    test_abort();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
